// File: rtl/dtw_pkg.sv
// dtw_pkg: shared FSM state type and 4-input popcount helper for double_trouble_window.
package dtw_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
    endfunction

endpackage

// File: rtl/dt_hit.sv
// dt_hit: combinational 2-of-4 vote detector.
module dt_hit
    import dtw_pkg::*;
(
    input  logic [3:0] votes,
    output logic       hit
);

    assign hit = popcnt4(votes) >= 3'd2;

endmodule

// File: rtl/double_trouble_window.sv
// double_trouble_window: counts 2-of-4 vote hits over a window of samples and presents a threshold flag.
// Define DTW_COUNT_EN to expose the window hit count on out_count.
module double_trouble_window
    import dtw_pkg::*;
#(
    parameter  int WINDOW = 8,
    parameter  int THRESH = 4,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_c,
    input  logic             in_d,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_flag
`ifdef DTW_COUNT_EN
    ,
    output logic [CNT_W-1:0] out_count
`endif
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hit_cnt, sample_cnt, hit_nxt, sample_nxt;
    logic             hit, accept, full, done;

    dt_hit u_hit (
        .votes({in_a, in_b, in_c, in_d}),
        .hit  (hit)
    );

    assign in_ready  = state != HOLD;
    assign out_valid = state == HOLD;
    assign out_flag  = out_valid && hit_cnt >= CNT_W'(THRESH);
`ifdef DTW_COUNT_EN
    assign out_count = out_valid ? hit_cnt : '0;
`endif

    // IDLE counters are already zero, so loading the first sample is just an add.
    always_comb begin
        accept     = in_valid && in_ready;
        done       = out_valid && out_ready;
        full       = accept && (sample_cnt + CNT_W'(1)) == CNT_W'(WINDOW);
        sample_nxt = done ? '0 : sample_cnt + CNT_W'(accept);
        hit_nxt    = done ? '0 : hit_cnt + CNT_W'(accept && hit);
        state_nxt  = (state == HOLD) ? (out_ready ? IDLE : HOLD)
                   : (full || (flush && (state == ACCUM || accept))) ? HOLD
                   : accept ? ACCUM : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            hit_cnt    <= '0;
            sample_cnt <= '0;
        end else begin
            state      <= state_nxt;
            hit_cnt    <= hit_nxt;
            sample_cnt <= sample_nxt;
        end
    end

endmodule
